// File: rtl/fifo_byte_serializer.sv
// Reader-side drain of the DAQ sample FIFO: pops one word, streams it MSB byte first
// on a valid/ready byte interface, forwards flushes as FIFO clears, flags underflow.
module fifo_byte_serializer #(
   parameter int LENGTH       = 68,
   parameter int BYTE_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              flush,
   input  logic [LENGTH-1:0] fifo_o_data,
   input  logic              fifo_empty,
   input  logic              fifo_empty_err,
   output logic              fifo_read,
   output logic              fifo_clear,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              underflow_err,
   input  logic              err_clear,
   output logic [15:0]       words_sent
);

   localparam int NBYTES = (LENGTH + BYTE_W - 1) / BYTE_W;
   localparam int PAD_W  = NBYTES * BYTE_W;
   localparam int IDX_W  = $clog2(NBYTES + 1);
   localparam int CNT_W  = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_SEND
   } state_t;

   state_t            r_state;
   logic [PAD_W-1:0]  r_shift;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_fifo_read;
   logic              r_fifo_clear;
   logic [BYTE_W-1:0] r_m_data;
   logic              r_m_valid;
   logic              r_m_last;
   logic              r_busy;
   logic              r_underflow;
   logic [15:0]       r_words_sent;

   logic [PAD_W-1:0]  w_padded;
   logic              w_xfer;
   logic              w_wait_done;

   // Zero-extend at the MSB so the word splits into a whole number of bytes.
   assign w_padded    = PAD_W'(fifo_o_data);
   assign w_xfer      = r_m_valid & m_ready;
   assign w_wait_done = (r_wait_cnt == CNT_W'(READ_LATENCY - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_idx        <= '0;
         r_wait_cnt   <= '0;
         r_fifo_read  <= 1'b0;
         r_fifo_clear <= 1'b0;
         r_m_data     <= '0;
         r_m_valid    <= 1'b0;
         r_m_last     <= 1'b0;
         r_busy       <= 1'b0;
         r_underflow  <= 1'b0;
         r_words_sent <= '0;
      end else begin
         r_fifo_read  <= 1'b0;
         r_fifo_clear <= 1'b0;

         // A new error outranks a simultaneous clear so no event is lost.
         if (fifo_empty_err) begin
            r_underflow <= 1'b1;
         end else if (err_clear) begin
            r_underflow <= 1'b0;
         end

         if (flush) begin
            r_fifo_clear <= 1'b1;
            r_state      <= S_IDLE;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_busy       <= 1'b0;
            r_wait_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (enable && !fifo_empty) begin
                     r_state     <= S_POP;
                     r_fifo_read <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end

               S_POP: begin
                  r_state    <= S_WAIT;
                  r_wait_cnt <= '0;
               end

               S_WAIT: begin
                  if (w_wait_done) begin
                     r_shift   <= w_padded << BYTE_W;
                     r_m_data  <= w_padded[PAD_W-1 -: BYTE_W];
                     r_idx     <= '0;
                     r_m_valid <= 1'b1;
                     r_m_last  <= (NBYTES == 1);
                     r_state   <= S_SEND;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 1'b1;
                  end
               end

               S_SEND: begin
                  if (w_xfer) begin
                     if (r_m_last) begin
                        r_m_valid    <= 1'b0;
                        r_m_last     <= 1'b0;
                        r_words_sent <= r_words_sent + 16'd1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                     end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_m_data <= r_shift[PAD_W-1 -: BYTE_W];
                        r_shift  <= r_shift << BYTE_W;
                        r_m_last <= (r_idx == IDX_W'(NBYTES - 2));
                     end
                  end
               end

               default: begin
                  r_state   <= S_IDLE;
                  r_m_valid <= 1'b0;
                  r_m_last  <= 1'b0;
                  r_busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign fifo_read     = r_fifo_read;
   assign fifo_clear    = r_fifo_clear;
   assign m_data        = r_m_data;
   assign m_valid       = r_m_valid;
   assign m_last        = r_m_last;
   assign busy          = r_busy;
   assign underflow_err = r_underflow;
   assign words_sent    = r_words_sent;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Self-checking bench for fifo_byte_serializer: a queue-based FIFO model with read
// latency feeds the DUT, and received bytes are compared to the MSB-first split of each word.
module tb_fifo_byte_serializer;

   localparam int LENGTH   = 68;
   localparam int BYTE_W   = 8;
   localparam int RL       = 2;
   localparam int NBYTES   = 9;
   localparam int WORD_CYC = NBYTES + RL + 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              flush;
   logic [LENGTH-1:0] fifo_o_data = '0;
   logic              fifo_empty = 1'b1;
   logic              fifo_empty_err;
   logic              fifo_read;
   logic              fifo_clear;
   logic [BYTE_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic              busy;
   logic              underflow_err;
   logic              err_clear;
   logic [15:0]       words_sent;

   int checks = 0;
   int errors = 0;

   logic [LENGTH-1:0] fifo_q[$];
   logic [LENGTH-1:0] pipe [0:RL];
   logic [7:0]        rx_data[$];
   logic              rx_last[$];
   int                last_cyc[$];
   int                cyc = 0;
   int                n_reads = 0;
   int                n_clears = 0;
   int                n_stalls = 0;
   int                stall_viol = 0;
   logic              prev_stall = 1'b0;
   logic              prev_flush = 1'b0;
   logic              prev_last = 1'b0;
   logic [7:0]        prev_data = '0;
   logic [15:0]       exp_words = '0;

   fifo_byte_serializer #(
      .LENGTH(LENGTH),
      .BYTE_W(BYTE_W),
      .READ_LATENCY(RL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .flush(flush),
      .fifo_o_data(fifo_o_data),
      .fifo_empty(fifo_empty),
      .fifo_empty_err(fifo_empty_err),
      .fifo_read(fifo_read),
      .fifo_clear(fifo_clear),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_last(m_last),
      .busy(busy),
      .underflow_err(underflow_err),
      .err_clear(err_clear),
      .words_sent(words_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [LENGTH-1:0] rand_word();
      return {4'($urandom), $urandom, $urandom};
   endfunction

   // Byte i of a word counted from the MSB end of the zero-padded word.
   function automatic logic [7:0] exp_byte(input logic [LENGTH-1:0] w, input int i);
      logic [NBYTES*8-1:0] p;
      p = {{(NBYTES*8-LENGTH){1'b0}}, w};
      return 8'(p >> (8 * (NBYTES - 1 - i)));
   endfunction

   // FIFO model: a pop becomes visible on fifo_o_data RL cycles after the read strobe.
   always @(negedge clk) begin
      if (fifo_clear) fifo_q.delete();
      for (int s = RL; s > 0; s--) pipe[s] = pipe[s-1];
      if (fifo_read && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
      else pipe[0] = rand_word();
      fifo_o_data = pipe[RL];
      fifo_empty  = (fifo_q.size() == 0);
   end

   // Stream monitor: records transfers and strobes, tracks hold-while-stalled.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         rx_data.push_back(m_data);
         rx_last.push_back(m_last);
         if (m_last) last_cyc.push_back(cyc);
      end
      if (fifo_read) n_reads++;
      if (fifo_clear) n_clears++;
      if (m_valid && !m_ready) n_stalls++;
      if (prev_stall && !prev_flush && (!m_valid || m_data !== prev_data || m_last !== prev_last))
         stall_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_flush = flush;
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({fifo_read, fifo_clear, m_valid, m_last, busy, underflow_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {fifo_read, fifo_clear, m_valid, m_last, busy, underflow_err});
      end
      checks++;
      if (m_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_m_data: got %h expected 00", m_data);
      end
      checks++;
      if (words_sent !== 16'h0000) begin
         errors++;
         $display("FAIL reset_words_sent: got %h expected 0000", words_sent);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      enable = 1'b1;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, m_valid, fifo_read} !== 3'b000) begin
         errors++;
         $display("FAIL idle_empty: busy/valid/read got %b expected 000", {busy, m_valid, fifo_read});
      end
      $display("test_reset done");
   endtask

   task automatic test_single_word();
      logic [LENGTH-1:0] w = 68'h1_2345_6789_ABCD_EF01;
      int base = rx_data.size();
      bit done = 0;
      m_ready = 1'b1;
      fifo_q.push_back(w);
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         if (rx_data.size() >= base + NBYTES) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL single_timeout: got %0d bytes expected %0d", rx_data.size() - base, NBYTES);
      end
      for (int i = 0; i < NBYTES && base + i < rx_data.size(); i++) begin
         checks++;
         if (rx_data[base+i] !== exp_byte(w, i) || rx_last[base+i] !== (i == NBYTES - 1)) begin
            errors++;
            $display("FAIL single_byte%0d: got %h last=%b expected %h last=%b",
                     i, rx_data[base+i], rx_last[base+i], exp_byte(w, i), (i == NBYTES - 1));
         end
      end
      exp_words++;
      checks++;
      if (words_sent !== exp_words) begin
         errors++;
         $display("FAIL single_words: got %0d expected %0d", words_sent, exp_words);
      end
      $display("test_single_word word %h sent", w);
   endtask

   task automatic test_stall();
      logic [LENGTH-1:0] w = 68'h1_2345_6789_ABCD_EF01;
      int base = rx_data.size();
      int sv0 = stall_viol;
      int ns0 = n_stalls;
      bit done = 0;
      fifo_q.push_back(w);
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk); #1;
         m_ready = ~m_ready;
         if (rx_data.size() >= base + NBYTES) done = 1;
      end
      m_ready = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL stall_timeout: got %0d bytes expected %0d", rx_data.size() - base, NBYTES);
      end
      for (int i = 0; i < NBYTES && base + i < rx_data.size(); i++) begin
         checks++;
         if (rx_data[base+i] !== exp_byte(w, i) || rx_last[base+i] !== (i == NBYTES - 1)) begin
            errors++;
            $display("FAIL stall_byte%0d: got %h last=%b expected %h last=%b",
                     i, rx_data[base+i], rx_last[base+i], exp_byte(w, i), (i == NBYTES - 1));
         end
      end
      checks++;
      if (stall_viol - sv0 != 0) begin
         errors++;
         $display("FAIL stall_hold: got %0d unstable stalls expected 0", stall_viol - sv0);
      end
      checks++;
      if (n_stalls - ns0 <= 0) begin
         errors++;
         $display("FAIL stall_seen: got %0d stall cycles expected >0", n_stalls - ns0);
      end
      exp_words++;
      checks++;
      if (words_sent !== exp_words) begin
         errors++;
         $display("FAIL stall_words: got %0d expected %0d", words_sent, exp_words);
      end
      $display("test_stall word %h sent with %0d stall cycles", w, n_stalls - ns0);
   endtask

   task automatic test_back_to_back();
      logic [LENGTH-1:0] ws[3];
      int base = rx_data.size();
      int r0 = n_reads;
      int lc0 = last_cyc.size();
      bit done = 0;
      m_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ws[k] = rand_word();
         fifo_q.push_back(ws[k]);
      end
      for (int i = 0; i < 150 && !done; i++) begin
         @(posedge clk); #1;
         if (rx_data.size() >= base + 3 * NBYTES) done = 1;
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d bytes expected %0d", rx_data.size() - base, 3 * NBYTES);
      end
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NBYTES && base + k * NBYTES + i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[base+k*NBYTES+i] !== exp_byte(ws[k], i)
                || rx_last[base+k*NBYTES+i] !== (i == NBYTES - 1)) begin
               errors++;
               $display("FAIL b2b_w%0d_byte%0d: got %h expected %h", k, i,
                        rx_data[base+k*NBYTES+i], exp_byte(ws[k], i));
            end
         end
         $display("test_back_to_back word %0d %h", k, ws[k]);
      end
      checks++;
      if (n_reads - r0 != 3) begin
         errors++;
         $display("FAIL b2b_reads: got %0d expected 3", n_reads - r0);
      end
      for (int k = 1; k < 3 && lc0 + k < last_cyc.size(); k++) begin
         checks++;
         if (last_cyc[lc0+k] - last_cyc[lc0+k-1] != WORD_CYC) begin
            errors++;
            $display("FAIL b2b_period%0d: got %0d cycles expected %0d",
                     k, last_cyc[lc0+k] - last_cyc[lc0+k-1], WORD_CYC);
         end
      end
      exp_words += 16'd3;
      checks++;
      if (words_sent !== exp_words) begin
         errors++;
         $display("FAIL b2b_words: got %0d expected %0d", words_sent, exp_words);
      end
   endtask

   task automatic test_flush();
      logic [LENGTH-1:0] wa = rand_word();
      logic [LENGTH-1:0] wb = rand_word();
      int base = rx_data.size();
      int c0 = n_clears;
      int r0;
      bit done = 0;
      int nlast = 0;
      m_ready = 1'b1;
      fifo_q.push_back(wa);
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         if (rx_data.size() >= base + 4) done = 1;
      end
      flush = 1'b1;
      m_ready = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_valid, fifo_clear, busy} !== 3'b010) begin
         errors++;
         $display("FAIL flush_next: valid/clear/busy got %b expected 010", {m_valid, fifo_clear, busy});
      end
      @(posedge clk); #1;
      checks++;
      if (n_clears - c0 != 1 || fifo_clear !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear_once: got %0d pulses expected 1", n_clears - c0);
      end
      for (int i = base; i < rx_data.size(); i++) if (rx_last[i]) nlast++;
      checks++;
      if (!done || rx_data.size() - base != 4 || nlast != 0) begin
         errors++;
         $display("FAIL flush_partial: got %0d bytes, %0d last expected 4 bytes, 0 last",
                  rx_data.size() - base, nlast);
      end
      checks++;
      if (words_sent !== exp_words) begin
         errors++;
         $display("FAIL flush_words: got %0d expected %0d", words_sent, exp_words);
      end
      base = rx_data.size();
      done = 0;
      fifo_q.push_back(wb);
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         if (rx_data.size() >= base + NBYTES) done = 1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL flush_restart_timeout: got %0d bytes expected %0d", rx_data.size() - base, NBYTES);
      end
      for (int i = 0; i < NBYTES && base + i < rx_data.size(); i++) begin
         checks++;
         if (rx_data[base+i] !== exp_byte(wb, i)) begin
            errors++;
            $display("FAIL flush_restart_byte%0d: got %h expected %h", i, rx_data[base+i], exp_byte(wb, i));
         end
      end
      exp_words++;
      // Held flush with a non-empty FIFO: one clear per cycle and no pop.
      r0 = n_reads;
      c0 = n_clears;
      flush = 1'b1;
      fifo_q.push_back(rand_word());
      repeat (3) @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (n_clears - c0 != 3 || n_reads - r0 != 0) begin
         errors++;
         $display("FAIL flush_held: got %0d clears %0d reads expected 3 clears 0 reads",
                  n_clears - c0, n_reads - r0);
      end
      $display("test_flush aborted %h, then sent %h", wa, wb);
   endtask

   task automatic test_underflow();
      @(posedge clk); #1;
      fifo_empty_err = 1'b1;
      err_clear = 1'b1;
      @(posedge clk); #1;
      fifo_empty_err = 1'b0;
      err_clear = 1'b0;
      checks++;
      if (underflow_err !== 1'b1) begin
         errors++;
         $display("FAIL uf_set_wins: got %b expected 1", underflow_err);
      end
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      checks++;
      if (underflow_err !== 1'b0) begin
         errors++;
         $display("FAIL uf_clear: got %b expected 0", underflow_err);
      end
      fifo_empty_err = 1'b1;
      @(posedge clk); #1;
      fifo_empty_err = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (underflow_err !== 1'b1) begin
         errors++;
         $display("FAIL uf_flush_keeps: got %b expected 1", underflow_err);
      end
      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      $display("test_underflow done");
   endtask

   task automatic test_enable();
      logic [LENGTH-1:0] w1 = rand_word();
      logic [LENGTH-1:0] w2 = rand_word();
      int base = rx_data.size();
      int r0 = n_reads;
      bit done = 0;
      m_ready = 1'b1;
      enable = 1'b0;
      fifo_q.push_back(w1);
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (n_reads - r0 != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL en_blocked: got %0d reads busy=%b expected 0 reads busy=0", n_reads - r0, busy);
      end
      fifo_q.push_back(w2);
      enable = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         if (rx_data.size() >= base + 3) done = 1;
      end
      enable = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (!done || rx_data.size() - base != NBYTES || n_reads - r0 != 1 || fifo_q.size() != 1) begin
         errors++;
         $display("FAIL en_mid_send: got %0d bytes %0d reads q=%0d expected %0d bytes 1 read q=1",
                  rx_data.size() - base, n_reads - r0, fifo_q.size(), NBYTES);
      end
      for (int i = 0; i < NBYTES && base + i < rx_data.size(); i++) begin
         checks++;
         if (rx_data[base+i] !== exp_byte(w1, i)) begin
            errors++;
            $display("FAIL en_byte%0d: got %h expected %h", i, rx_data[base+i], exp_byte(w1, i));
         end
      end
      exp_words++;
      checks++;
      if (words_sent !== exp_words) begin
         errors++;
         $display("FAIL en_words: got %0d expected %0d", words_sent, exp_words);
      end
      enable = 1'b1;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         if (rx_data.size() >= base + 2 * NBYTES) done = 1;
      end
      exp_words++;
      checks++;
      if (!done || rx_data[base+NBYTES] !== exp_byte(w2, 0) || words_sent !== exp_words) begin
         errors++;
         $display("FAIL en_resume: got words %0d expected %0d", words_sent, exp_words);
      end
      $display("test_enable sent %h then %h", w1, w2);
   endtask

   task automatic test_random();
      logic [LENGTH-1:0] ws[6];
      int base = rx_data.size();
      int sv0 = stall_viol;
      bit done = 0;
      enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ws[k] = rand_word();
         fifo_q.push_back(ws[k]);
      end
      for (int i = 0; i < 1000 && !done; i++) begin
         @(posedge clk); #1;
         m_ready = 1'($urandom_range(0, 1));
         if (rx_data.size() >= base + 6 * NBYTES) done = 1;
      end
      m_ready = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL rand_timeout: got %0d bytes expected %0d", rx_data.size() - base, 6 * NBYTES);
      end
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NBYTES && base + k * NBYTES + i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[base+k*NBYTES+i] !== exp_byte(ws[k], i)
                || rx_last[base+k*NBYTES+i] !== (i == NBYTES - 1)) begin
               errors++;
               $display("FAIL rand_w%0d_byte%0d: got %h expected %h", k, i,
                        rx_data[base+k*NBYTES+i], exp_byte(ws[k], i));
            end
         end
         $display("test_random word %0d %h", k, ws[k]);
      end
      exp_words += 16'd6;
      checks++;
      if (words_sent !== exp_words || stall_viol - sv0 != 0) begin
         errors++;
         $display("FAIL rand_words_hold: got words %0d viol %0d expected %0d viol 0",
                  words_sent, stall_viol - sv0, exp_words);
      end
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      flush = 1'b0;
      fifo_empty_err = 1'b0;
      err_clear = 1'b0;
      m_ready = 1'b0;
      test_reset();
      test_single_word();
      test_stall();
      test_back_to_back();
      test_flush();
      test_underflow();
      test_enable();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
